ajc_nbit_pattern_const_unit_v: RTL and testbench
================================================

Name: ajc_nbit_pattern_const_unit_v

Overview:
Parametrised, registered successor to the 8-bit fixed-constant ALU source. Generates WIDTH-bit constants and patterns: four fixed patterns, a loadable user constant, a walking-one, an up-counter and a Galois LFSR. Drives Const_Result/Const_CNVZ into the ALU result mux alongside the arithmetic and logic units, with a Const_Valid qualifier.

Parameters:
WIDTH, 8, data width in bits (>=4)
SEED, 8'h01, LFSR reset/recovery value; must be nonzero, WIDTH bits
TAPS, 8'hB8, Galois LFSR feedback mask, WIDTH bits

Ports:
Clock  input  1  rising-edge clock
Resetn  input  1  asynchronous active-low reset
Enable  input  1  output register update enable
Func_Sel  input  3  pattern/mode select
Step  input  1  advance the selected generator (modes 101/110/111)
Load_En  input  1  write Load_Data into user constant register
Load_Data  input  WIDTH  user constant value
Const_Result  output  WIDTH  registered constant/pattern
Const_CNVZ  output  4  registered flags {C,N,V,Z}
Const_Valid  output  1  Const_Result/Const_CNVZ updated this cycle

Behaviour:
- One clock; reset is asynchronous and active-low (Resetn).
- Reset values: Const_Result=0, Const_CNVZ=4'b0000, Const_Valid=0, user_reg=0, walk_reg=1 (LSB set), count_reg=0, lfsr_reg=SEED.
- Func_Sel decode, all WIDTH bits:
  - 000: all ones.
  - 001: 1010... (MSB=1).
  - 010: 0101... (MSB=0).
  - 011: all zeros.
  - 100: user_reg.
  - 101: walk_reg.
  - 110: count_reg.
  - 111: lfsr_reg.
- Latency: one cycle. On an edge with Enable=1, Const_Result <= the selected value after any same-edge generator update, and Const_Valid <= 1. With Enable=0, Const_Result/Const_CNVZ hold and Const_Valid <= 0.
- Generators advance only when Enable=1, Step=1 and Func_Sel selects them. Non-selected generators hold; switching back resumes from the held state.
  - walk_reg rotates left by 1; MSB wraps to LSB.
  - count_reg <= count_reg+1 mod 2^WIDTH.
  - lfsr_reg <= (lfsr_reg>>1) ^ (lfsr_reg[0] ? TAPS : 0).
- Step in modes 000-100 is ignored.
- LFSR lock-up guard: if lfsr_reg==0, the next advance loads SEED.
- Load_En writes user_reg regardless of Enable.
  - Write-through: if Load_En=1, Enable=1 and Func_Sel=100 on the same edge, Const_Result <= Load_Data.
- Flags, registered with Const_Result, computed from the new value:
  - N = MSB [WIDTH-1].
  - Z = NOR of all bits.
  - V = 0 always.
  - C = 1 only on the edge where count_reg wraps all-ones -> 0 in mode 110 with Step; otherwise 0.
- Reset asserted mid-operation clears all state immediately; the first Enable edge after release presents reset-state values.

Test Plan:
- WIDTH=8, reset, Enable=1, Func_Sel 000/001/010/011 on successive cycles -> Const_Result FF/AA/55/00 one cycle later; CNVZ 0100/0100/0000/0001; Const_Valid=1.
- Load_En=1, Load_Data=8'h3C, Func_Sel=100, Enable=1 same edge -> Const_Result=3C, CNVZ=0000. Then Enable=0 -> outputs hold, Const_Valid=0.
- Func_Sel=101, Step=1 for 8 cycles -> 02,04,08,10,20,40,80,01. CNVZ=0100 on the 80 cycle, else 0000.
- Func_Sel=110 with Step held -> counter steps 01,02,…; at FF -> next edge Result=00, CNVZ=1001; following edge 01, C=0. Drop Step for 3 cycles -> value holds.
- Func_Sel=111, SEED=01, TAPS=B8, Step=1 -> B8, 5C, 2E, 17. Switch to 110 then back to 111 -> resumes from 17.
- Assert Resetn=0 mid LFSR/counter run -> outputs 0, Const_Valid=0 asynchronously. After release, Func_Sel=111 with Enable=1 and Step=0 -> 01; Func_Sel=110 -> 00 with CNVZ=0001.

Source files
------------

// File: rtl/ajc_nbit_pattern_const_unit_v.sv
// ajc_nbit_pattern_const_unit_v
// Registered WIDTH-bit constant/pattern source for the ALU result mux.
// Fixed patterns, a loadable user constant and three steppable generators
// (walking one, up-counter, Galois LFSR) feed a single output register
// with {C,N,V,Z} flags and a one-cycle valid qualifier.
module ajc_nbit_pattern_const_unit_v #(
   parameter int               WIDTH = 8,
   parameter logic [WIDTH-1:0] SEED  = WIDTH'(8'h01),
   parameter logic [WIDTH-1:0] TAPS  = WIDTH'(8'hB8)
) (
   input  logic             Clock,
   input  logic             Resetn,
   input  logic             Enable,
   input  logic [2:0]       Func_Sel,
   input  logic             Step,
   input  logic             Load_En,
   input  logic [WIDTH-1:0] Load_Data,
   output logic [WIDTH-1:0] Const_Result,
   output logic [3:0]       Const_CNVZ,
   output logic             Const_Valid
);

   localparam logic [2:0] SEL_ONES  = 3'b000;
   localparam logic [2:0] SEL_ALT_A = 3'b001;
   localparam logic [2:0] SEL_ALT_5 = 3'b010;
   localparam logic [2:0] SEL_ZEROS = 3'b011;
   localparam logic [2:0] SEL_USER  = 3'b100;
   localparam logic [2:0] SEL_WALK  = 3'b101;
   localparam logic [2:0] SEL_COUNT = 3'b110;
   localparam logic [2:0] SEL_LFSR  = 3'b111;

   logic [WIDTH-1:0] user_reg;
   logic [WIDTH-1:0] walk_reg;
   logic [WIDTH-1:0] count_reg;
   logic [WIDTH-1:0] lfsr_reg;

   logic [WIDTH-1:0] pat_alt;
   logic             step_walk;
   logic             step_count;
   logic             step_lfsr;
   logic [WIDTH-1:0] walk_next;
   logic [WIDTH-1:0] count_next;
   logic [WIDTH-1:0] lfsr_next;
   logic [WIDTH-1:0] result_next;
   logic             carry_next;

   // Alternating pattern with the MSB set (1010...); its inverse is 0101...
   always_comb begin
      pat_alt = '0;
      for (int i = 0; i < WIDTH; i++) begin
         if (((WIDTH - 1 - i) % 2) == 0) pat_alt[i] = 1'b1;
      end
   end

   // Generator step qualifiers and their next-state values.
   always_comb begin
      step_walk  = Enable && Step && (Func_Sel == SEL_WALK);
      step_count = Enable && Step && (Func_Sel == SEL_COUNT);
      step_lfsr  = Enable && Step && (Func_Sel == SEL_LFSR);

      walk_next  = step_walk  ? {walk_reg[WIDTH-2:0], walk_reg[WIDTH-1]} : walk_reg;
      count_next = step_count ? count_reg + 1'b1 : count_reg;

      lfsr_next = lfsr_reg;
      if (step_lfsr) begin
         if (lfsr_reg == '0) lfsr_next = SEED;  // recover from lock-up state
         else                lfsr_next = (lfsr_reg >> 1) ^ (lfsr_reg[0] ? TAPS : '0);
      end

      carry_next = step_count && (count_reg == '1);
   end

   // Output select; generator modes present the post-step value.
   always_comb begin
      result_next = '0;
      unique case (Func_Sel)
         SEL_ONES:  result_next = '1;
         SEL_ALT_A: result_next = pat_alt;
         SEL_ALT_5: result_next = ~pat_alt;
         SEL_ZEROS: result_next = '0;
         SEL_USER:  result_next = Load_En ? Load_Data : user_reg;
         SEL_WALK:  result_next = walk_next;
         SEL_COUNT: result_next = count_next;
         SEL_LFSR:  result_next = lfsr_next;
         default:   result_next = '0;
      endcase
   end

   // User constant loads independently of Enable.
   always_ff @(posedge Clock or negedge Resetn) begin
      if (!Resetn)      user_reg <= '0;
      else if (Load_En) user_reg <= Load_Data;
   end

   // Generator registers; next values already hold when not stepping.
   always_ff @(posedge Clock or negedge Resetn) begin
      if (!Resetn) begin
         walk_reg  <= WIDTH'(1);
         count_reg <= '0;
         lfsr_reg  <= SEED;
      end else begin
         walk_reg  <= walk_next;
         count_reg <= count_next;
         lfsr_reg  <= lfsr_next;
      end
   end

   // Output register: result and flags update together under Enable.
   always_ff @(posedge Clock or negedge Resetn) begin
      if (!Resetn) begin
         Const_Result <= '0;
         Const_CNVZ   <= 4'b0000;
         Const_Valid  <= 1'b0;
      end else if (Enable) begin
         Const_Result <= result_next;
         Const_CNVZ   <= {carry_next, result_next[WIDTH-1], 1'b0, ~|result_next};
         Const_Valid  <= 1'b1;
      end else begin
         Const_Valid  <= 1'b0;
      end
   end

endmodule

// File: tb/tb_ajc_nbit_pattern_const_unit_v.sv
// Directed bench for ajc_nbit_pattern_const_unit_v at WIDTH=8, SEED=01, TAPS=B8.
module tb_ajc_nbit_pattern_const_unit_v;

   logic       Clock;
   logic       Resetn;
   logic       Enable;
   logic [2:0] Func_Sel;
   logic       Step;
   logic       Load_En;
   logic [7:0] Load_Data;
   logic [7:0] Const_Result;
   logic [3:0] Const_CNVZ;
   logic       Const_Valid;

   int n_checks = 0;
   int n_fail   = 0;

   ajc_nbit_pattern_const_unit_v #(
      .WIDTH (8),
      .SEED  (8'h01),
      .TAPS  (8'hB8)
   ) dut (
      .Clock        (Clock),
      .Resetn       (Resetn),
      .Enable       (Enable),
      .Func_Sel     (Func_Sel),
      .Step         (Step),
      .Load_En      (Load_En),
      .Load_Data    (Load_Data),
      .Const_Result (Const_Result),
      .Const_CNVZ   (Const_CNVZ),
      .Const_Valid  (Const_Valid)
   );

   initial Clock = 1'b0;
   always #5 Clock = ~Clock;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge Clock);
      #1;
   endtask

   task automatic chk_out(input string tag, input logic [7:0] res,
                          input logic [3:0] cnvz, input logic vld);
      chk({tag, ".res"},  32'(Const_Result), 32'(res));
      chk({tag, ".cnvz"}, 32'(Const_CNVZ),   32'(cnvz));
      chk({tag, ".vld"},  32'(Const_Valid),  32'(vld));
   endtask

   logic [7:0] walk_exp [8] = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h01};
   logic [7:0] lfsr_exp [4] = '{8'hB8, 8'h5C, 8'h2E, 8'h17};

   initial begin
      Resetn = 1'b0; Enable = 1'b0; Func_Sel = 3'b000; Step = 1'b0;
      Load_En = 1'b0; Load_Data = 8'h00;
      #12;
      chk_out("reset", 8'h00, 4'b0000, 1'b0);
      @(negedge Clock);
      Resetn = 1'b1;

      // fixed patterns
      Enable = 1'b1;
      Func_Sel = 3'b000; Step = 1'b1; tick(); chk_out("ones", 8'hFF, 4'b0100, 1'b1);
      Func_Sel = 3'b001; tick(); chk_out("alt_a", 8'hAA, 4'b0100, 1'b1);
      Func_Sel = 3'b010; tick(); chk_out("alt_5", 8'h55, 4'b0000, 1'b1);
      Func_Sel = 3'b011; tick(); chk_out("zeros", 8'h00, 4'b0001, 1'b1);
      Step = 1'b0;

      // user constant with write-through, then hold
      Func_Sel = 3'b100; Load_En = 1'b1; Load_Data = 8'h3C;
      tick(); chk_out("user_wt", 8'h3C, 4'b0000, 1'b1);
      Load_En = 1'b0; Enable = 1'b0;
      tick(); chk_out("hold", 8'h3C, 4'b0000, 1'b0);
      Load_En = 1'b1; Load_Data = 8'h5A;
      tick(); chk_out("load_noen", 8'h3C, 4'b0000, 1'b0);
      Load_En = 1'b0; Enable = 1'b1;
      tick(); chk_out("user_rd", 8'h5A, 4'b0000, 1'b1);

      // walking one
      Func_Sel = 3'b101; Step = 1'b1;
      for (int i = 0; i < 8; i++) begin
         tick();
         chk_out($sformatf("walk%0d", i), walk_exp[i],
                 (walk_exp[i] == 8'h80) ? 4'b0100 : 4'b0000, 1'b1);
      end

      // counter through wrap
      Func_Sel = 3'b110;
      for (int i = 1; i < 256; i++) begin
         tick();
         chk($sformatf("cnt%0d", i), 32'(Const_Result), i);
      end
      chk("cnt_ff.cnvz", 32'(Const_CNVZ), 32'b0100);
      tick(); chk_out("cnt_wrap", 8'h00, 4'b1001, 1'b1);
      tick(); chk_out("cnt_after", 8'h01, 4'b0000, 1'b1);
      Step = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick(); chk_out($sformatf("cnt_hold%0d", i), 8'h01, 4'b0000, 1'b1);
      end

      // LFSR
      Func_Sel = 3'b111; Step = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         chk($sformatf("lfsr%0d", i), 32'(Const_Result), 32'(lfsr_exp[i]));
      end
      Func_Sel = 3'b110; Step = 1'b0;
      tick(); chk_out("sw_cnt", 8'h01, 4'b0000, 1'b1);
      Func_Sel = 3'b111;
      tick(); chk_out("lfsr_resume", 8'h17, 4'b0000, 1'b1);
      Step = 1'b1;
      tick(); chk_out("lfsr_next", 8'hB3, 4'b0100, 1'b1);

      // asynchronous reset mid-run
      #2;
      Resetn = 1'b0;
      #1;
      chk_out("async_rst", 8'h00, 4'b0000, 1'b0);
      @(negedge Clock);
      Resetn = 1'b1; Step = 1'b0; Func_Sel = 3'b111;
      tick(); chk_out("rst_lfsr", 8'h01, 4'b0000, 1'b1);
      Func_Sel = 3'b110;
      tick(); chk_out("rst_cnt", 8'h00, 4'b0001, 1'b1);
      Func_Sel = 3'b101;
      tick(); chk_out("rst_walk", 8'h01, 4'b0000, 1'b1);
      Func_Sel = 3'b100;
      tick(); chk_out("rst_user", 8'h00, 4'b0001, 1'b1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
